// File: rtl/switch_status_monitor.sv
// Three-channel switch on-time monitor: per-channel duration FSMs, stuck/overlap/loss flags,
// and a small report FIFO drained over a valid/ready interface.
//   state   | meaning
//   S_IDLE  | switch low, no period being timed
//   S_ON    | switch high, duration below TIMEOUT
//   S_STUCK | switch high, duration reached TIMEOUT
module switch_status_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 90,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             switch1,
    input  logic             switch2,
    input  logic             switch3,
    input  logic             fault_clr,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W+2:0] rpt_data,
    output logic [2:0]       stuck,
    output logic             overlap,
    output logic             ovf,
    output logic [23:0]      on_events
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = CNT_W + 3;
    localparam logic [CNT_W-1:0] DUR_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DUR_ONE   = CNT_W'(1);
    localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_STUCK} state_t;

    state_t           r_state [3];
    state_t           w_state_nxt [3];
    logic [CNT_W-1:0] r_dur [3];
    logic [CNT_W-1:0] w_dur_nxt [3];
    logic [CNT_W-1:0] w_dur_inc [3];
    logic [RW-1:0]    w_rec [3];
    logic [RW-1:0]    r_pend [3];
    logic [2:0]       r_pend_vld;
    logic [2:0]       w_sw, r_sw_q, w_rise, w_fall;
    logic [2:0]       w_load, w_stuck_set, w_push_oh;
    logic [7:0]       r_on_cnt [3];
    logic [2:0]       r_stuck;
    logic             r_overlap, r_ovf;
    logic             w_multi, w_lost, w_push, w_pop, w_can_push;
    logic [RW-1:0]    w_push_data;
    logic [RW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;

    assign w_sw   = {switch3, switch2, switch1};
    assign w_rise = w_sw & ~r_sw_q;
    assign w_fall = ~w_sw & r_sw_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            w_dur_nxt[i]   = r_dur[i];
            w_stuck_set[i] = 1'b0;
            w_load[i]      = 1'b0;
            w_dur_inc[i]   = (r_dur[i] == DUR_MAX) ? r_dur[i] : r_dur[i] + DUR_ONE;
            w_rec[i]       = {2'(i), (r_state[i] == S_STUCK), r_dur[i]};
            case (r_state[i])
                S_IDLE: begin
                    if (w_rise[i]) begin
                        w_dur_nxt[i] = DUR_ONE;
                        if (DUR_ONE >= TIMEOUT_C) begin
                            w_state_nxt[i] = S_STUCK;
                            w_stuck_set[i] = 1'b1;
                        end else begin
                            w_state_nxt[i] = S_ON;
                        end
                    end
                end
                S_ON: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_dur_nxt[i]   = '0;
                        w_load[i]      = 1'b1;
                    end else if (w_sw[i]) begin
                        w_dur_nxt[i] = w_dur_inc[i];
                        if (w_dur_inc[i] >= TIMEOUT_C) begin
                            w_state_nxt[i] = S_STUCK;
                            w_stuck_set[i] = 1'b1;
                        end
                    end
                end
                S_STUCK: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_dur_nxt[i]   = '0;
                        w_load[i]      = 1'b1;
                    end else if (w_sw[i]) begin
                        w_dur_nxt[i] = w_dur_inc[i];
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_dur_nxt[i]   = '0;
                end
            endcase
        end
    end

    // A full FIFO can still accept a record when a pop happens in the same cycle.
    assign rpt_valid  = (r_count != '0);
    assign w_pop      = rpt_valid & rpt_ready;
    assign w_can_push = (r_count != DEPTH_C) | w_pop;

    always_comb begin
        w_push_oh = 3'b000;
        if (w_can_push) begin
            if (r_pend_vld[0])      w_push_oh = 3'b001;
            else if (r_pend_vld[1]) w_push_oh = 3'b010;
            else if (r_pend_vld[2]) w_push_oh = 3'b100;
        end
    end

    assign w_push      = |w_push_oh;
    assign w_push_data = w_push_oh[0] ? r_pend[0] : (w_push_oh[1] ? r_pend[1] : r_pend[2]);
    assign w_lost      = |(w_load & r_pend_vld & ~w_push_oh);
    assign w_multi     = (r_sw_q[0] & r_sw_q[1]) | (r_sw_q[0] & r_sw_q[2]) | (r_sw_q[1] & r_sw_q[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_q     <= '0;
            r_pend_vld <= '0;
            r_stuck    <= '0;
            r_overlap  <= 1'b0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_state[i]  <= S_IDLE;
                r_dur[i]    <= '0;
                r_pend[i]   <= '0;
                r_on_cnt[i] <= '0;
            end
        end else begin
            r_sw_q <= w_sw;
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_dur[i]   <= w_dur_nxt[i];
                if (w_load[i]) begin
                    r_pend[i]     <= w_rec[i];
                    r_pend_vld[i] <= 1'b1;
                end else if (w_push_oh[i]) begin
                    r_pend_vld[i] <= 1'b0;
                end
                if (w_rise[i] && (r_on_cnt[i] != 8'hFF)) r_on_cnt[i] <= r_on_cnt[i] + 8'd1;
            end
            // Sets take priority over a coincident clear.
            r_stuck   <= (fault_clr ? 3'b000 : r_stuck) | w_stuck_set;
            r_overlap <= (fault_clr ? 1'b0 : r_overlap) | w_multi;
            r_ovf     <= (fault_clr ? 1'b0 : r_ovf) | w_lost;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign rpt_data  = r_mem[r_rd_ptr];
    assign stuck     = r_stuck;
    assign overlap   = r_overlap;
    assign ovf       = r_ovf;
    assign on_events = {r_on_cnt[2], r_on_cnt[1], r_on_cnt[0]};

endmodule

// File: tb/tb_switch_status_monitor.sv
// Bench for switch_status_monitor: directed scenarios plus random switch traffic, checked
// against a run-length model of each channel and per-channel queues of expected records.
module tb_switch_status_monitor;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 90;
    localparam int RW      = CNT_W + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0;
    logic          fault_clr = 1'b0, rpt_ready = 1'b1;
    logic          rpt_valid, overlap, ovf;
    logic [RW-1:0] rpt_data;
    logic [2:0]    stuck;
    logic [23:0]   on_events;

    switch_status_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .switch1(switch1), .switch2(switch2), .switch3(switch3),
        .fault_clr(fault_clr), .rpt_ready(rpt_ready), .rpt_valid(rpt_valid),
        .rpt_data(rpt_data), .stuck(stuck), .overlap(overlap), .ovf(ovf),
        .on_events(on_events)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            npops = 0;
    int            run [3];
    logic [2:0]    prev;
    logic [2:0]    exp_stuck;
    logic          exp_ovl;
    int            exp_on [3];
    logic [RW-1:0] expq [3][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev = '0;
        exp_stuck = '0;
        exp_ovl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            exp_on[i] = 0;
            expq[i].delete();
        end
    endtask

    task automatic check_pop();
        logic [RW-1:0] d, e;
        int ch;
        logic ok;
        d = rpt_data;
        ch = int'(d[RW-1:RW-2]);
        npops++;
        ok = (ch < 3) ? (expq[ch].size() > 0) : 1'b0;
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL pop_expected observed=%0h expected=a_pending_record", d);
        end
        if (ok) begin
            e = expq[ch].pop_front();
            chk("pop_record", 64'(d), 64'(e));
        end
    endtask

    // One clock: consume a popped record, advance the model on the current inputs,
    // step the clock, then compare the flag outputs.
    task automatic tick();
        logic [2:0] s, set;
        int pc;
        if (rpt_valid && rpt_ready) check_pop();
        s = {switch3, switch2, switch1};
        set = '0;
        pc = int'(prev[0]) + int'(prev[1]) + int'(prev[2]);
        for (int i = 0; i < 3; i++) begin
            if (s[i]) begin
                if (!prev[i] && exp_on[i] < 255) exp_on[i]++;
                if (run[i] < 65535) run[i]++;
                if (run[i] == TIMEOUT) set[i] = 1'b1;
            end else if (prev[i]) begin
                expq[i].push_back({2'(i), (run[i] >= TIMEOUT), 16'(run[i])});
                run[i] = 0;
            end
        end
        exp_stuck = (fault_clr ? 3'b000 : exp_stuck) | set;
        exp_ovl = (fault_clr ? 1'b0 : exp_ovl) | (pc >= 2);
        prev = s;
        @(posedge clk);
        #1;
        chk("stuck", 64'(stuck), 64'(exp_stuck));
        chk("overlap", 64'(overlap), 64'(exp_ovl));
        chk("on_events", 64'(on_events), 64'({8'(exp_on[2]), 8'(exp_on[1]), 8'(exp_on[0])}));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(rpt_valid), 64'd0);
        chk({tag, "_data"}, 64'(rpt_data), 64'd0);
        chk({tag, "_stuck"}, 64'(stuck), 64'd0);
        chk({tag, "_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_on_events"}, 64'(on_events), 64'd0);
    endtask

    initial begin
        int n0;
        int rem [3];
        logic [2:0] sw;
        model_reset();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        #4;

        // Single 10-cycle press on channel 0
        switch1 = 1'b1;
        repeat (10) tick();
        switch1 = 1'b0;
        tick();
        chk("lat_valid_low", 64'(rpt_valid), 64'd0);
        tick();
        chk("lat_valid_high", 64'(rpt_valid), 64'd1);
        chk("rec_ch0", 64'(rpt_data), 64'({2'd0, 1'b0, 16'd10}));
        chk("on_events0", 64'(on_events[7:0]), 64'd1);
        repeat (2) tick();

        // Stuck detection on channel 1
        switch2 = 1'b1;
        repeat (89) tick();
        chk("stuck1_before", 64'(stuck[1]), 64'd0);
        tick();
        chk("stuck1_at_timeout", 64'(stuck[1]), 64'd1);
        repeat (10) tick();
        switch2 = 1'b0;
        repeat (2) tick();
        chk("rec_ch1", 64'(rpt_data), 64'({2'd1, 1'b1, 16'd100}));
        repeat (2) tick();

        // Overlap and same-cycle falls on all channels
        {switch3, switch2, switch1} = 3'b111;
        repeat (5) tick();
        {switch3, switch2, switch1} = 3'b000;
        tick();
        chk("overlap_set", 64'(overlap), 64'd1);
        tick();
        chk("arb_ch0", 64'(rpt_data), 64'({2'd0, 1'b0, 16'd5}));
        tick();
        chk("arb_ch1", 64'(rpt_data), 64'({2'd1, 1'b0, 16'd5}));
        tick();
        chk("arb_ch2", 64'(rpt_data), 64'({2'd2, 1'b0, 16'd5}));
        tick();
        chk("arb_drained", 64'(rpt_valid), 64'd0);

        // Back-pressure: fill the FIFO, one pending, one lost
        rpt_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            switch3 = 1'b1;
            repeat (2) tick();
            switch3 = 1'b0;
            repeat (2) tick();
            if (p == 4) chk("ovf_before_6th", 64'(ovf), 64'd0);
        end
        chk("ovf_after_6th", 64'(ovf), 64'd1);
        chk("full_valid", 64'(rpt_valid), 64'd1);
        void'(expq[2].pop_back());
        rpt_ready = 1'b1;
        n0 = npops;
        repeat (8) tick();
        chk("drain_count", 64'(npops - n0), 64'd5);
        chk("drain_empty", 64'(rpt_valid), 64'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // Clear coinciding with a stuck set, then a later clear
        switch1 = 1'b1;
        repeat (89) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("stuck0_set_wins", 64'(stuck[0]), 64'd1);
        repeat (3) tick();
        switch1 = 1'b0;
        repeat (4) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("stuck0_cleared", 64'(stuck[0]), 64'd0);

        // on_events saturation
        repeat (260) begin
            switch1 = 1'b1;
            tick();
            switch1 = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk("on_events_sat", 64'(on_events[7:0]), 64'd255);

        // Random traffic
        sw = '0;
        for (int i = 0; i < 3; i++) rem[i] = $urandom_range(1, 4);
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    sw[i] = ~sw[i];
                    rem[i] = (sw[i] && $urandom_range(0, 19) == 0) ?
                             int'($urandom_range(90, 110)) : int'($urandom_range(2, 6));
                end
                rem[i]--;
            end
            {switch3, switch2, switch1} = sw;
            fault_clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        {switch3, switch2, switch1} = 3'b000;
        fault_clr = 1'b0;
        repeat (6) tick();
        chk("rand_all_reported", 64'(expq[0].size() + expq[1].size() + expq[2].size()), 64'd0);
        chk("rand_no_ovf", 64'(ovf), 64'd0);

        // Mid-run asynchronous reset
        {switch2, switch1} = 2'b11;
        repeat (5) tick();
        switch1 = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        {switch3, switch2, switch1} = 3'b000;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #4;
        repeat (3) tick();
        chk("post_reset_valid", 64'(rpt_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
